// File: rtl/native_axi_pkg.sv
// Shared constants and state encoding for the native-app to AXI4 master bridge.
//   CMD_WRITE / CMD_READ   : app_cmd codes the bridge acts on (others are dropped)
//   AXI_BURST_INCR         : AXI burst type driven on every AW/AR
//   AXI_RESP_OKAY          : expected bresp/rresp; anything else sets resp_err
//   NATIVE_MASTER_STATE    : control FSM states
package native_axi_pkg;

    localparam logic [2:0] CMD_WRITE      = 3'd0;
    localparam logic [2:0] CMD_READ       = 3'd1;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        WR_AW,
        WR_W,
        WR_B,
        RD_AR,
        RD_R
    } NATIVE_MASTER_STATE;

endpackage

// File: rtl/axi4_if.sv
// AXI4 bus bundle (AW/W/B/AR/R channels, no lock/cache/prot/qos/user).
//   master modport : drives addresses, write data and ready on B/R
//   slave  modport : mirror image, used by memories/models
interface axi4_if #(
    parameter int ADDR_WIDTH = 27,
    parameter int DATA_WIDTH = 256,
    parameter int ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;

    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/native_wdata_fifo.sv
// Synchronous show-ahead FIFO holding write beats (data + strobe) until the
// AXI W channel drains them.
//   clock, rst  : clock / async active-high reset (pointers and count flushed)
//   push, din   : write port, ignored when full
//   pop, dout   : read port, dout is the current head, pop ignored when empty
//   full, empty, count : occupancy
module native_wdata_fifo #(
    parameter int WIDTH = 288,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/native_to_axi4_master.sv
// MIG-style native app port (slave side) bridged onto an AXI4 master.
// Consecutive contiguous same-type commands are coalesced into one INCR burst
// of up to BURST_LEN beats; a burst closes when full, after IDLE_TIMEOUT idle
// cycles, or when a non-mergeable command arrives (that command is parked in a
// one-entry pending register and opens the next burst).
//   clock, rst          : clock / async active-high reset
//   axi_inf             : AXI4 master port
//   app_addr/cmd/en/rdy : command handshake
//   app_wdf_*           : write data stream into the write FIFO
//   app_rd_data*        : read return, straight from the R channel
//   init_calib_complete : high from the first clock after reset release
//   resp_err            : sticky error on any non-OKAY bresp/rresp
module native_to_axi4_master
    import native_axi_pkg::*;
#(
    parameter int ADDR_WIDTH   = 27,
    parameter int DATA_WIDTH   = 256,
    parameter int ADDR_STEP    = 8,
    parameter int BURST_LEN    = 16,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic                    clock,
    input  logic                    rst,
    axi4_if.master                  axi_inf,
    input  logic [ADDR_WIDTH-1:0]   app_addr,
    input  logic [2:0]              app_cmd,
    input  logic                    app_en,
    output logic                    app_rdy,
    input  logic [DATA_WIDTH-1:0]   app_wdf_data,
    input  logic [DATA_WIDTH/8-1:0] app_wdf_mask,
    input  logic                    app_wdf_wren,
    input  logic                    app_wdf_end,
    output logic                    app_wdf_rdy,
    output logic [DATA_WIDTH-1:0]   app_rd_data,
    output logic                    app_rd_data_valid,
    output logic                    app_rd_data_end,
    output logic                    init_calib_complete,
    output logic                    resp_err
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int BW = $clog2(BURST_LEN + 1);
    localparam int TW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [2:0] AXSIZE = 3'($clog2(SW));

    typedef struct packed {
        logic                  rd;
        logic [ADDR_WIDTH-1:0] addr;
    } app_req_t;

    NATIVE_MASTER_STATE    state;
    app_req_t              head, pend;
    logic                  pend_vld;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic [BW-1:0]         beats, xfer_cnt, fifo_cnt;
    logic [TW-1:0]         timer;
    logic                  wr_wait;

    logic                  cmd_ok, cmd_rd, accept, room, contig, breaks, close;
    logic                  fifo_full, fifo_empty, wvalid, w_hs, burst_done, last_xfer;
    logic [SW-1:0]         fifo_strb;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic [7:0]            ax_len;
    logic                  unused_ok;

    assign unused_ok = ^{axi_inf.bid, axi_inf.rid, app_wdf_end};

    // ---------------- write data FIFO ----------------
    native_wdata_fifo #(.WIDTH(DATA_WIDTH + SW), .DEPTH(BURST_LEN), .CW(BW)) u_wfifo (
        .clock (clock),
        .rst   (rst),
        .push  (app_wdf_wren && app_wdf_rdy),
        .din   ({app_wdf_data, ~app_wdf_mask}),
        .pop   (w_hs),
        .dout  ({fifo_data, fifo_strb}),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    assign app_wdf_rdy = init_calib_complete && !fifo_full;

    // ---------------- command side ----------------
    assign cmd_ok = (app_cmd == CMD_WRITE) || (app_cmd == CMD_READ);
    assign cmd_rd = (app_cmd == CMD_READ);
    assign room   = beats < BW'(BURST_LEN);
    assign app_rdy = init_calib_complete && !pend_vld &&
                     ((state == IDLE) || (state == COLLECT && !wr_wait && room));
    assign accept = app_en && app_rdy;
    assign contig = accept && cmd_ok && (cmd_rd == head.rd) &&
                    (app_addr == last_addr + ADDR_WIDTH'(ADDR_STEP));
    assign breaks = accept && cmd_ok && !contig;
    // A merge wins over the timeout in the same cycle; wr_wait re-evaluates
    // the FIFO level every cycle until enough data has arrived.
    assign close  = (state == COLLECT) &&
                    (wr_wait || !room || breaks || (!contig && timer == TW'(IDLE_TIMEOUT)));

    // ---------------- AXI side ----------------
    assign ax_len    = 8'(beats) - 8'd1;
    assign wvalid    = (state == WR_W) && !fifo_empty;
    assign w_hs      = wvalid && axi_inf.wready;
    assign last_xfer = (xfer_cnt == beats - BW'(1));
    assign burst_done = (state == WR_B && axi_inf.bvalid) ||
                        (state == RD_R && axi_inf.rvalid && (axi_inf.rlast || last_xfer));

    assign axi_inf.awid    = '0;
    assign axi_inf.awvalid = (state == WR_AW);
    assign axi_inf.awaddr  = (state == WR_AW) ? head.addr : '0;
    assign axi_inf.awlen   = (state == WR_AW) ? ax_len : 8'd0;
    assign axi_inf.awsize  = (state == WR_AW) ? AXSIZE : 3'd0;
    assign axi_inf.awburst = (state == WR_AW) ? AXI_BURST_INCR : 2'b00;

    assign axi_inf.wvalid  = wvalid;
    assign axi_inf.wdata   = wvalid ? fifo_data : '0;
    assign axi_inf.wstrb   = wvalid ? fifo_strb : '0;
    assign axi_inf.wlast   = wvalid && last_xfer;
    assign axi_inf.bready  = (state == WR_B);

    assign axi_inf.arid    = '0;
    assign axi_inf.arvalid = (state == RD_AR);
    assign axi_inf.araddr  = (state == RD_AR) ? head.addr : '0;
    assign axi_inf.arlen   = (state == RD_AR) ? ax_len : 8'd0;
    assign axi_inf.arsize  = (state == RD_AR) ? AXSIZE : 3'd0;
    assign axi_inf.arburst = (state == RD_AR) ? AXI_BURST_INCR : 2'b00;
    // No read backpressure; held low only while in reset.
    assign axi_inf.rready  = init_calib_complete;

    assign app_rd_data       = axi_inf.rdata;
    assign app_rd_data_valid = axi_inf.rvalid && init_calib_complete;
    assign app_rd_data_end   = axi_inf.rvalid && init_calib_complete;

    // ---------------- control FSM ----------------
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state               <= IDLE;
            head                <= '0;
            pend                <= '0;
            pend_vld            <= 1'b0;
            last_addr           <= '0;
            beats               <= '0;
            timer               <= '0;
            wr_wait             <= 1'b0;
            xfer_cnt            <= '0;
            init_calib_complete <= 1'b0;
            resp_err            <= 1'b0;
        end else begin
            init_calib_complete <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept && cmd_ok) begin
                        head      <= '{rd: cmd_rd, addr: app_addr};
                        last_addr <= app_addr;
                        beats     <= BW'(1);
                        timer     <= '0;
                        state     <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (contig) begin
                        beats     <= beats + BW'(1);
                        last_addr <= app_addr;
                        timer     <= '0;
                    end else if (timer != TW'(IDLE_TIMEOUT)) begin
                        timer <= timer + TW'(1);
                    end
                    if (breaks) begin
                        pend_vld <= 1'b1;
                        pend     <= '{rd: cmd_rd, addr: app_addr};
                    end
                    if (close) begin
                        if (head.rd) begin
                            state <= RD_AR;
                        end else if (fifo_cnt >= beats) begin
                            state   <= WR_AW;
                            wr_wait <= 1'b0;
                        end else begin
                            wr_wait <= 1'b1;
                        end
                    end
                end
                WR_AW: begin
                    if (axi_inf.awready) begin
                        state    <= WR_W;
                        xfer_cnt <= '0;
                    end
                end
                WR_W: begin
                    if (w_hs) begin
                        xfer_cnt <= xfer_cnt + BW'(1);
                        if (last_xfer) state <= WR_B;
                    end
                end
                WR_B: begin
                    if (axi_inf.bvalid && axi_inf.bresp != AXI_RESP_OKAY) resp_err <= 1'b1;
                end
                RD_AR: begin
                    if (axi_inf.arready) begin
                        state    <= RD_R;
                        xfer_cnt <= '0;
                    end
                end
                RD_R: begin
                    if (axi_inf.rvalid) begin
                        xfer_cnt <= xfer_cnt + BW'(1);
                        if (axi_inf.rresp != AXI_RESP_OKAY) resp_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // The parked command opens the next burst without a new handshake.
            if (burst_done) begin
                if (pend_vld) begin
                    head      <= pend;
                    last_addr <= pend.addr;
                    beats     <= BW'(1);
                    timer     <= '0;
                    pend_vld  <= 1'b0;
                    state     <= COLLECT;
                end else begin
                    state <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_native_to_axi4_master.sv
module tb_native_to_axi4_master;
    import native_axi_pkg::*;

    localparam int AW = 27;
    localparam int DW = 256;
    localparam int SW = DW / 8;
    localparam int BL = 16;
    localparam int TO = 16;

    logic clock = 1'b0;
    logic rst   = 1'b1;
    always #5 clock = ~clock;

    axi4_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi_bus ();

    logic [AW-1:0] app_addr;
    logic [2:0]    app_cmd;
    logic          app_en, app_rdy;
    logic [DW-1:0] app_wdf_data;
    logic [SW-1:0] app_wdf_mask;
    logic          app_wdf_wren, app_wdf_end, app_wdf_rdy;
    logic [DW-1:0] app_rd_data;
    logic          app_rd_data_valid, app_rd_data_end;
    logic          init_calib_complete, resp_err;

    native_to_axi4_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ADDR_STEP(8), .BURST_LEN(BL), .IDLE_TIMEOUT(TO)
    ) dut (
        .clock               (clock),
        .rst                 (rst),
        .axi_inf             (axi_bus),
        .app_addr            (app_addr),
        .app_cmd             (app_cmd),
        .app_en              (app_en),
        .app_rdy             (app_rdy),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_mask        (app_wdf_mask),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .app_wdf_rdy         (app_wdf_rdy),
        .app_rd_data         (app_rd_data),
        .app_rd_data_valid   (app_rd_data_valid),
        .app_rd_data_end     (app_rd_data_end),
        .init_calib_complete (init_calib_complete),
        .resp_err            (resp_err)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int i);
        return {8{32'hC0DE_0000 + 32'(i)}};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d, input logic [SW-1:0] m);
        int n = 0;
        app_wdf_data = d;
        app_wdf_mask = m;
        app_wdf_wren = 1'b1;
        while (!app_wdf_rdy && n < 200) begin tick(); n++; end
        check("wdf_rdy", app_wdf_rdy, 1);
        tick();
        app_wdf_wren = 1'b0;
    endtask

    task automatic cmd(input logic [2:0] c, input logic [AW-1:0] a);
        int n = 0;
        app_cmd  = c;
        app_addr = a;
        app_en   = 1'b1;
        while (!app_rdy && n < 200) begin tick(); n++; end
        check("cmd_rdy", app_rdy, 1);
        tick();
        app_en = 1'b0;
    endtask

    task automatic wait_valid(input bit rd);
        int n = 0;
        while (!(rd ? axi_bus.arvalid : axi_bus.awvalid) && n < 200) begin tick(); n++; end
        check(rd ? "arvalid" : "awvalid", rd ? axi_bus.arvalid : axi_bus.awvalid, 1);
    endtask

    // Full write burst as seen from the slave: AW, all W beats, then B.
    task automatic axi_write(input logic [AW-1:0] a, input int beats, input int base,
                             input logic [SW-1:0] strb, input logic [1:0] resp);
        wait_valid(0);
        check("awaddr", axi_bus.awaddr, a);
        check("awlen", axi_bus.awlen, beats - 1);
        check("awsize", axi_bus.awsize, 3'd5);
        check("awburst", axi_bus.awburst, 2'b01);
        axi_bus.awready = 1'b1;
        tick();
        axi_bus.awready = 1'b0;
        check("aw_drop", axi_bus.awvalid, 0);
        axi_bus.wready = 1'b1;
        for (int i = 0; i < beats; i++) begin
            check("wvalid", axi_bus.wvalid, 1);
            check("wdata", axi_bus.wdata, pat(base + i));
            check("wstrb", axi_bus.wstrb, strb);
            check("wlast", axi_bus.wlast, (i == beats - 1));
            tick();
        end
        axi_bus.wready = 1'b0;
        check("w_drop", axi_bus.wvalid, 0);
        check("bready", axi_bus.bready, 1);
        axi_bus.bvalid = 1'b1;
        axi_bus.bresp  = resp;
        tick();
        axi_bus.bvalid = 1'b0;
        axi_bus.bresp  = 2'b00;
        check("b_drop", axi_bus.bready, 0);
    endtask

    // Read burst; gap_sel holds 2-bit idle-cycle counts inserted before each beat.
    task automatic axi_read(input logic [AW-1:0] a, input int beats, input int base,
                            input logic [31:0] gap_sel);
        int pulses = 0;
        wait_valid(1);
        check("araddr", axi_bus.araddr, a);
        check("arlen", axi_bus.arlen, beats - 1);
        check("arsize", axi_bus.arsize, 3'd5);
        check("arburst", axi_bus.arburst, 2'b01);
        axi_bus.arready = 1'b1;
        tick();
        axi_bus.arready = 1'b0;
        check("ar_drop", axi_bus.arvalid, 0);
        check("rready", axi_bus.rready, 1);
        for (int i = 0; i < beats; i++) begin
            for (int g = 0; g < int'((gap_sel >> (2 * i)) & 32'd3); g++) begin
                #1;
                check("rd_gap_valid", app_rd_data_valid, 0);
                tick();
            end
            axi_bus.rvalid = 1'b1;
            axi_bus.rdata  = pat(base + i);
            axi_bus.rlast  = (i == beats - 1);
            #1;
            check("rd_valid", app_rd_data_valid, 1);
            check("rd_end", app_rd_data_end, 1);
            check("rd_data", app_rd_data, pat(base + i));
            if (app_rd_data_valid) pulses++;
            tick();
            axi_bus.rvalid = 1'b0;
            axi_bus.rlast  = 1'b0;
            axi_bus.rdata  = '0;
        end
        check("rd_pulses", pulses, beats);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        app_addr = '0; app_cmd = 3'd0; app_en = 1'b0;
        app_wdf_data = '0; app_wdf_mask = '0; app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
        axi_bus.awready = 1'b0; axi_bus.wready = 1'b0;
        axi_bus.bvalid = 1'b0; axi_bus.bresp = 2'b00; axi_bus.bid = '0;
        axi_bus.arready = 1'b0;
        axi_bus.rvalid = 1'b0; axi_bus.rdata = '0; axi_bus.rresp = 2'b00;
        axi_bus.rlast = 1'b0; axi_bus.rid = '0;

        // ---- reset state ----
        tick(); tick();
        check("rst_app_rdy", app_rdy, 0);
        check("rst_calib", init_calib_complete, 0);
        check("rst_wdf_rdy", app_wdf_rdy, 0);
        check("rst_awvalid", axi_bus.awvalid, 0);
        check("rst_arvalid", axi_bus.arvalid, 0);
        check("rst_rready", axi_bus.rready, 0);
        check("rst_resp_err", resp_err, 0);
        rst = 1'b0;
        check("rel_calib_before_edge", init_calib_complete, 0);
        tick();
        check("rel_calib", init_calib_complete, 1);
        check("rel_app_rdy", app_rdy, 1);

        // ---- single write, timeout close; accept cycle + TO + 2 to awvalid ----
        push(pat(1), 32'h0000_000F);
        cmd(CMD_WRITE, 27'h100);
        check("t1_rdy_collect", app_rdy, 1);
        cyc = 1;
        while (!axi_bus.awvalid && cyc < 100) begin tick(); cyc++; end
        check("t1_latency", cyc, TO + 2);
        axi_write(27'h100, 1, 1, 32'hFFFF_FFF0, 2'b00);
        check("t1_idle_rdy", app_rdy, 1);

        // ---- 16 contiguous writes -> one full burst ----
        for (int i = 0; i < BL; i++) push(pat(16 + i), '0);
        check("t2_fifo_full", app_wdf_rdy, 0);
        for (int i = 0; i < BL; i++) cmd(CMD_WRITE, AW'(i * 8));
        check("t2_rdy_full", app_rdy, 0);
        check("t2_aw_not_yet", axi_bus.awvalid, 0);
        tick();
        check("t2_aw_next_cycle", axi_bus.awvalid, 1);
        axi_write(27'h0, BL, 16, '1, 2'b00);
        check("t2_fifo_drained", app_wdf_rdy, 1);

        // ---- write 0x0,0x8 then read 0x10 (type change -> pending) ----
        push(pat(40), '0);
        push(pat(41), '0);
        cmd(CMD_WRITE, 27'h0);
        cmd(CMD_WRITE, 27'h8);
        cmd(CMD_READ, 27'h10);
        check("t3_rdy_pending", app_rdy, 0);
        check("t3_aw_closed", axi_bus.awvalid, 1);
        axi_write(27'h0, 2, 40, '1, 2'b00);
        check("t3_rdy_after_b", app_rdy, 1);
        check("t3_no_ar_yet", axi_bus.arvalid, 0);
        axi_read(27'h10, 1, 50, 32'h0);
        check("t3_idle", app_rdy, 1);

        // ---- 4 contiguous reads, rvalid with gaps 0,1,2,1 ----
        for (int i = 0; i < 4; i++) cmd(CMD_READ, AW'(27'h200 + i * 8));
        axi_read(27'h200, 4, 60, 32'h64);
        check("t4_idle", app_rdy, 1);
        check("t4_no_ar", axi_bus.arvalid, 0);

        // ---- error response is sticky; next burst normal ----
        push(pat(70), '0);
        cmd(CMD_WRITE, 27'h300);
        axi_write(27'h300, 1, 70, '1, 2'b10);
        check("t5_err_set", resp_err, 1);
        push(pat(71), '0);
        cmd(CMD_WRITE, 27'h400);
        axi_write(27'h400, 1, 71, '1, 2'b00);
        check("t5_err_sticky", resp_err, 1);

        // ---- async reset during W beat 3 ----
        for (int i = 0; i < 4; i++) push(pat(80 + i), '0);
        for (int i = 0; i < 4; i++) cmd(CMD_WRITE, AW'(27'h500 + i * 8));
        wait_valid(0);
        check("t6_awlen", axi_bus.awlen, 3);
        axi_bus.awready = 1'b1;
        tick();
        axi_bus.awready = 1'b0;
        axi_bus.wready = 1'b1;
        tick(); tick(); tick();
        axi_bus.wready = 1'b0;
        check("t6_beat3_wdata", axi_bus.wdata, pat(83));
        check("t6_beat3_wlast", axi_bus.wlast, 1);
        #1;
        rst = 1'b1;
        #1;
        check("t6_rst_wvalid", axi_bus.wvalid, 0);
        check("t6_rst_awvalid", axi_bus.awvalid, 0);
        check("t6_rst_bready", axi_bus.bready, 0);
        check("t6_rst_app_rdy", app_rdy, 0);
        check("t6_rst_wdf_rdy", app_wdf_rdy, 0);
        check("t6_rst_calib", init_calib_complete, 0);
        check("t6_rst_err", resp_err, 0);
        tick();
        rst = 1'b0;
        tick();
        check("t6_rel_app_rdy", app_rdy, 1);
        check("t6_rel_wdf_rdy", app_wdf_rdy, 1);
        // FIFO flushed: a write without data must stall in COLLECT.
        cmd(CMD_WRITE, 27'h600);
        repeat (TO + 6) tick();
        check("t6_flushed_no_aw", axi_bus.awvalid, 0);
        check("t6_wait_rdy", app_rdy, 0);
        push(pat(90), '0);
        axi_write(27'h600, 1, 90, '1, 2'b00);
        check("t6_final_idle", app_rdy, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
